data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32: data and address width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: the pipeline presents a load/store request.
REQ-005 SHALL have port req_ready, output, 1: the controller can accept a request.
REQ-006 SHALL have port req_we, input, 1: 1 means store, 0 means load.
REQ-007 SHALL have port req_funct3, input, 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, D_WIDTH: byte address.
REQ-009 SHALL have port req_wdata, input, D_WIDTH: store data, right-aligned.
REQ-010 SHALL have port mem_addr, output, D_WIDTH: word-aligned RAM address, with bits [1:0] set to 0.
REQ-011 SHALL have ports mem_re and mem_we, output, 1 each: RAM read and write strobes.
REQ-012 SHALL have port mem_be, output, 4: byte-lane write enables.
REQ-013 SHALL have port mem_wdata, output, D_WIDTH: lane-positioned store data.
REQ-014 SHALL have port mem_rdata, input, D_WIDTH: RAM read data, valid one cycle after mem_re.
REQ-015 SHALL have ports resp_valid and resp_err, output, 1 each: response handshake valid and misaligned/illegal flag.
REQ-016 SHALL have port resp_ready, input, 1: the pipeline accepts the response.
REQ-017 SHALL have port resp_rdata, output, D_WIDTH: extended load result.

Function
REQ-018 SHALL implement FSM states IDLE, STORE, LOAD_ADDR, LOAD_DATA, RESP.
REQ-019 SHALL assert req_ready only in IDLE.
REQ-020 SHALL capture we, funct3, addr and wdata on req_valid && req_ready; the request is then held internally, and later input changes SHALL have no effect.
REQ-021 SHALL treat the following as illegal: a halfword with addr[0]=1; a word with addr[1:0]!=00; funct3 of 011, 110 or 111.
REQ-022 On an illegal request, the FSM SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL assert no memory strobe.
REQ-023 On a legal store, the FSM SHALL go IDLE->STORE and then STORE->RESP; mem_we=1 for exactly one cycle, in STORE only.
REQ-024 mem_be SHALL be 0001<<addr[1:0] for a byte, 0011<<addr[1:0] for a half, and 1111 for a word; mem_wdata SHALL be wdata shifted left by 8*addr[1:0].
REQ-025 On a legal load, the FSM SHALL go IDLE->LOAD_ADDR->LOAD_DATA->RESP; mem_re=1 in LOAD_ADDR only.
REQ-026 In LOAD_DATA, the controller SHALL register a result from mem_rdata >> 8*addr[1:0]:
- B/H: sign-extended from bit 7 or bit 15.
- BU/HU: zero-extended.
- W: unmodified.
REQ-027 Latency from the accept cycle T: an error response at T+1, a store response at T+2, a load response at T+3.
REQ-028 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL stay stable until resp_ready=1; the FSM then returns to IDLE on the next cycle. A store response SHALL carry resp_rdata=0 and resp_err=0.
REQ-029 A new request SHALL NOT be accepted in the same cycle as a response handshake; the first possible accept is the cycle after the return to IDLE.
REQ-030 mem_addr SHALL equal {addr[D_WIDTH-1:2],2'b00} in STORE and LOAD_ADDR, and 0 otherwise; mem_be and mem_wdata SHALL be 0 outside STORE.

Reset
REQ-031 With rst=1 at a clock edge, the FSM SHALL enter IDLE and the controller SHALL drive: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset in any state, including mid-access or while a response is held, SHALL abort the operation with no further strobes and no response.

Verification
REQ-033 Signed byte load: addr=0x1002, funct3=000, mem_rdata=0x12AB3456. Required: mem_re at T+1 with mem_addr=0x1000, and resp_rdata=0xFFFFFFAB at T+3.
REQ-034 Unsigned half load: addr=0x2002, funct3=101, mem_rdata=0x8001FFFF. Required: resp_rdata=0x00008001 and resp_err=0.
REQ-035 Byte store: addr=0x3003, wdata=0x000000C5, funct3=000. Required: at T+1, mem_we=1, mem_be=1000, mem_wdata=0xC5000000, mem_addr=0x3000; resp_valid at T+2.
REQ-036 Misaligned word load: addr=0x4001, funct3=010. Required: no mem_re, and resp_valid=1 with resp_err=1 at T+1. Also funct3=011 -> same error response.
REQ-037 Response hold: hold resp_ready=0 for 5 cycles during a load response. Required: resp_valid and resp_rdata stay stable and req_ready=0; on resp_ready=1, IDLE follows the next cycle.
REQ-038 Reset mid-access: assert rst during LOAD_DATA. Required: req_ready=1 next cycle, with no resp_valid and no strobes afterward.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Load/store unit between the pipeline and a single-port word RAM: aligns
// stores into byte lanes, extracts and extends loads, flags illegal accesses.
module data_mem_ctrl #(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [D_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic               mem_re,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               resp_valid,
  output logic               resp_err,
  input  logic               resp_ready,
  output logic [D_WIDTH-1:0] resp_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD_ADDR,
    LOAD_DATA,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic               we_q;
  logic [2:0]         f3_q;
  logic [D_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] wdata_q;
  logic [D_WIDTH-1:0] rdata_q;
  logic               err_q;

  logic               illegal;
  logic [4:0]         lane_sh;
  logic [D_WIDTH-1:0] shifted;
  logic [D_WIDTH-1:0] load_ext;
  logic [3:0]         be_calc;

  assign lane_sh = {addr_q[1:0], 3'b000};

  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = req_addr[0];
      3'b010:         illegal = |req_addr[1:0];
      default:        illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal)     state_nxt = RESP;
          else if (req_we) state_nxt = STORE;
          else             state_nxt = LOAD_ADDR;
        end
      end
      STORE:     state_nxt = RESP;
      LOAD_ADDR: state_nxt = LOAD_DATA;
      LOAD_DATA: state_nxt = RESP;
      RESP:      if (resp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifted  = mem_rdata >> lane_sh;
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = {{(D_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(D_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(D_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(D_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // rdata_q is cleared on accept so error and store responses return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= illegal;
      end
      if (state == LOAD_DATA) rdata_q <= load_ext;
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   be_calc = 4'b0001 << addr_q[1:0];
      2'b01:   be_calc = 4'b0011 << addr_q[1:0];
      default: be_calc = 4'b1111;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_re     = (state == LOAD_ADDR);
    mem_we     = (state == STORE) && we_q;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = (state == RESP) ? rdata_q : '0;
    if (state == STORE || state == LOAD_ADDR)
      mem_addr = {addr_q[D_WIDTH-1:2], 2'b00};
    if (state == STORE) begin
      mem_be    = be_calc;
      mem_wdata = wdata_q << lane_sh;
    end
  end

endmodule
